// File: rtl/apb_cmd_master_if.sv
// ============================================================================
// Module      : apb_cmd_master_if
// Description : Command/response handshake plus APB3 master bus bundle for
//               apb_cmd_master. The PREADY wire exists only when the
//               APB_PREADY_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Local requester side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  // APB side
  logic [ADDR_W-1:0] PADDR;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
`ifdef APB_PREADY_EN
  logic              PREADY;
`endif

  // The sequencer's view
  modport master (
`ifdef APB_PREADY_EN
    input  PREADY,
`endif
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

  // The environment's view (requester plus APB slave)
  modport slave (
`ifdef APB_PREADY_EN
    output PREADY,
`endif
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );
endinterface

`default_nettype wire

// File: rtl/apb_cmd_master.sv
// ============================================================================
// Module      : apb_cmd_master
// Description : APB3 master sequencer. Buffers read/write commands in a small
//               FIFO, issues each as a SETUP/ACCESS transfer and returns one
//               response per command, in order.
//               Optional macro APB_PREADY_EN: adds PREADY wait-state support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic         PCLK,
  input  wire logic         PRESET,
  apb_cmd_master_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Command storage, one field per array
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [DEPTH-1:0]  mem_write;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_ptr, load_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, load;
  logic             access_done;

  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_write_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Refused while full even if the head pops on the same edge.
  assign bus.cmd_ready = !full && !PRESET;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign nxt_ptr       = rd_ptr + PTR_W'(1);

`ifdef APB_PREADY_EN
  assign access_done = bus.PREADY;
`else
  assign access_done = 1'b1;
`endif

  // Next-state and next-output decode; registers hold unless a case overrides.
  always_comb begin
    state_nxt     = state;
    psel_nxt      = bus.PSELx;
    penable_nxt   = bus.PENABLE;
    pwrite_nxt    = bus.PWRITE;
    paddr_nxt     = bus.PADDR;
    pwdata_nxt    = bus.PWDATA;
    rsp_valid_nxt = 1'b0;
    rsp_write_nxt = bus.rsp_write;
    rsp_rdata_nxt = bus.rsp_rdata;
    pop           = 1'b0;
    load          = 1'b0;
    load_ptr      = rd_ptr;

    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          load        = 1'b1;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (access_done) begin
          pop           = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = bus.PWRITE;
          if (!bus.PWRITE) begin
            rsp_rdata_nxt = bus.PRDATA;
          end
          // Back-to-back when another entry is already queued behind the head
          if (count > CNT_W'(1)) begin
            state_nxt   = SETUP;
            penable_nxt = 1'b0;
            load        = 1'b1;
            load_ptr    = nxt_ptr;
          end else begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase

    if (load) begin
      paddr_nxt  = mem_addr[load_ptr];
      pwdata_nxt = mem_wdata[load_ptr];
      pwrite_nxt = mem_write[load_ptr];
    end
  end

  // State register and registered APB / response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      bus.PSELx     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_nxt;
      bus.PSELx     <= psel_nxt;
      bus.PENABLE   <= penable_nxt;
      bus.PWRITE    <= pwrite_nxt;
      bus.PADDR     <= paddr_nxt;
      bus.PWDATA    <= pwdata_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      bus.rsp_write <= rsp_write_nxt;
      bus.rsp_rdata <= rsp_rdata_nxt;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= nxt_ptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates use.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_addr[wr_ptr]  <= bus.cmd_addr;
      mem_wdata[wr_ptr] <= bus.cmd_wdata;
      mem_write[wr_ptr] <= bus.cmd_write;
    end
  end

endmodule

`default_nettype wire
